rx_read_interface: RTL and testbench
====================================

Name: rx_read_interface

Overview:
- Host-side reader for the UART receive path; the counterpart of the write interface.
- Drains the RX FIFO one byte per host read request and holds the byte in a data register.
- Exposes a status register and tracks RX FIFO overrun and read underflow.
- Sits between the RX FIFO read port and board I/O (KEY/LED/HEX) inside the UART top.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and data_reg.
- CNT_WIDTH, 8, width of saturating overrun counter.

Ports:
- i_Clock  in  1  system clock, 50 MHz.
- i_reset  in  1  asynchronous, active-high reset.
- rd_req  in  1  raw asynchronous read request (key/switch), active-high.
- clr_status  in  1  synchronous clear of sticky flags and counter, active-high.
- fifo_empty  in  1  RX FIFO empty flag.
- fifo_full  in  1  RX FIFO full flag.
- fifo_wr  in  1  receiver write attempt into FIFO (rx_dv, ungated).
- fifo_data  in  DATA_WIDTH  RX FIFO data_out; registered read, valid the cycle after the rd_en edge.
- fifo_rd_en  out  1  FIFO pop strobe.
- data_reg  out  DATA_WIDTH  last byte read.
- data_valid  out  1  one-cycle pulse when data_reg updates.
- overrun_cnt  out  CNT_WIDTH  count of dropped writes.
- status_reg  out  8  {3'b0, busy, underflow_flag, overrun_flag, fifo_full, fifo_empty}, bit0 = fifo_empty.

Behaviour:
- Reset (async, i_reset=1): state IDLE; sync/edge flops 0; fifo_rd_en 0; data_reg 0; data_valid 0; overrun_cnt 0; flags 0; status_reg reflects live fifo_empty/fifo_full with other bits 0.
- rd_req path: 2-flop synchronizer plus a third flop for rising-edge detect; edge = s2 & ~s3. One pop per rising edge; holding rd_req high never re-triggers.
- FSM states: IDLE, POP, WAIT.
  - IDLE, edge & ~fifo_empty -> POP.
  - IDLE, edge & fifo_empty -> stays IDLE and sets underflow_flag (sticky).
  - POP: fifo_rd_en=1 for exactly this one cycle -> WAIT.
  - WAIT: on the exiting edge, data_reg <= fifo_data and data_valid=1 for the next cycle -> IDLE.
- Latency:
  - rd_req rising before edge E0 -> fifo_rd_en high in the cycle after E2.
  - fifo_rd_en -> data_valid: 2 cycles.
  - Back-to-back request min spacing: 3 cycles.
- Edges while in POP or WAIT are ignored: not queued, no underflow.
- fifo_empty is only sampled in IDLE. This block is the sole reader, so empty cannot assert in POP.
- busy = (state != IDLE).
- Overrun: fifo_wr & fifo_full in a cycle -> overrun_flag=1 (sticky) and overrun_cnt+1, saturating at 2^CNT_WIDTH-1 (no wrap).
- clr_status clears overrun_flag, underflow_flag and overrun_cnt next cycle. If a new event coincides with clr_status, the event wins: flag=1, cnt=1 (underflow likewise set).
- data_reg holds its value until the next successful read; clr_status does not affect data_reg.
- Reset mid-POP/WAIT aborts immediately. A FIFO pop already issued is lost (byte consumed, not latched) — this is accepted behaviour.

Decomposition:
- uart_pkg holds:
  - FSM state typedef (IDLE/POP/WAIT, 2-bit).
  - Status bit index constants: ST_EMPTY=0, ST_FULL=1, ST_OVR=2, ST_UDF=3, ST_BUSY=4.
  - Default DATA_WIDTH.
- One sub-module: sync_edge_detect (2-flop synchronizer + rising-edge pulse, async active-high reset), reusable for KEY inputs elsewhere.

Test Plan:
- Reset check: assert i_reset mid-WAIT -> all outputs 0 immediately (async), state IDLE, data_reg=0x00; FIFO with 0x5A pre-loaded stays unlatched.
- Single read: preload FIFO with 0xA5; pulse rd_req for 10 cycles -> exactly one fifo_rd_en pulse 3 cycles after rise; data_valid 2 cycles later with data_reg=0xA5; second pop absent.
- Back-to-back reads: FIFO holds 0x11,0x22,0x33; three rd_req rises spaced 5 cycles -> data_reg sequence 0x11,0x22,0x33; a fourth rise with fifo_empty=1 -> no fifo_rd_en, status_reg[3]=1.
- Ignored edge: second rd_req rise landing during WAIT -> no extra pop, underflow_flag stays 0.
- Overrun: hold fifo_full=1, fifo_wr high for 300 cycles (CNT_WIDTH=8) -> overrun_cnt=255 (saturated), status_reg[2]=1; clr_status -> cnt=0, flag=0.
- Simultaneous clear: clr_status and fifo_wr&fifo_full in the same cycle -> next cycle overrun_cnt=1, overrun_flag=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state, status bit positions and default widths for the UART blocks.
package uart_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVR   = 2;
    localparam int ST_UDF   = 3;
    localparam int ST_BUSY  = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        WAIT = 2'd2
    } rx_state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus a third flop giving a one-cycle rising-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic [2:0] s;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s <= '0;
        else     s <= {s[1:0], d};
    end
    assign pulse = s[1] & ~s[2];
endmodule

// File: rtl/rx_read_interface.sv
// rx_read_interface: pops one RX FIFO byte per host request edge, latches it and reports status.
module rx_read_interface
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_Clock,
    input  logic                  i_reset,
    input  logic                  rd_req,
    input  logic                  clr_status,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    input  logic                  fifo_wr,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] data_reg,
    output logic                  data_valid,
    output logic [CNT_WIDTH-1:0]  overrun_cnt,
    output logic [7:0]            status_reg
);
    rx_state_t state, next;
    logic      rd_edge, udf_evt, ovr_evt, ovr_flag, udf_flag;

    sync_edge_detect u_sync (
        .clk  (i_Clock),
        .rst  (i_reset),
        .d    (rd_req),
        .pulse(rd_edge)
    );

    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= next;
    end

    // Edges arriving outside IDLE are dropped on purpose: no queueing, no underflow.
    always_comb begin
        next       = state;
        fifo_rd_en = 1'b0;
        udf_evt    = 1'b0;
        case (state)
            IDLE: begin
                udf_evt = rd_edge & fifo_empty;
                next    = (rd_edge & ~fifo_empty) ? POP : IDLE;
            end
            POP: begin
                fifo_rd_en = 1'b1;
                next       = WAIT;
            end
            WAIT:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) begin
            data_reg   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= (state == WAIT);
            if (state == WAIT) data_reg <= fifo_data;
        end
    end

    assign ovr_evt = fifo_wr & fifo_full;

    // A fresh event in the clearing cycle takes precedence over the clear.
    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) begin
            ovr_flag    <= 1'b0;
            udf_flag    <= 1'b0;
            overrun_cnt <= '0;
        end else if (clr_status) begin
            ovr_flag    <= ovr_evt;
            udf_flag    <= udf_evt;
            overrun_cnt <= {{(CNT_WIDTH-1){1'b0}}, ovr_evt};
        end else begin
            ovr_flag <= ovr_flag | ovr_evt;
            udf_flag <= udf_flag | udf_evt;
            if (ovr_evt && ~&overrun_cnt) overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

    always_comb begin
        status_reg           = '0;
        status_reg[ST_EMPTY] = fifo_empty;
        status_reg[ST_FULL]  = fifo_full;
        status_reg[ST_OVR]   = ovr_flag;
        status_reg[ST_UDF]   = udf_flag;
        status_reg[ST_BUSY]  = (state != IDLE);
    end
endmodule

// File: tb/tb_rx_read_interface.sv
// tb_rx_read_interface: randomized and directed stimulus against a cycle-scheduled reference model.
module tb_rx_read_interface;
    logic       clk = 1'b0;
    logic       rst, rd_req, clr_status, fifo_empty, fifo_full, fifo_wr;
    logic [7:0] fifo_data, data_reg, overrun_cnt, status_reg;
    logic       fifo_rd_en, data_valid;

    always #10 clk = ~clk;

    rx_read_interface dut (
        .i_Clock    (clk),
        .i_reset    (rst),
        .rd_req     (rd_req),
        .clr_status (clr_status),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .data_reg   (data_reg),
        .data_valid (data_valid),
        .overrun_cnt(overrun_cnt),
        .status_reg (status_reg)
    );

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // FIFO environment: registered read, data appears the cycle after the pop edge
    logic [7:0] fifo_q[$];
    bit         pend;
    logic [7:0] pend_byte;

    // Reference model: request edges become scheduled pop/valid cycles
    logic [7:0] ref_q[$];
    int         cyc, m_busy_until, m_rd_at, m_dv_at, m_cnt;
    logic [7:0] m_dv_byte, m_data;
    bit         r1, r2, prev_rd, m_ovr, m_udf;

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        ref_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic model_clear();
        m_busy_until = 0; m_rd_at = -1; m_dv_at = -1; m_cnt = 0;
        m_data = 8'h00; r1 = 0; r2 = 0; prev_rd = 0; m_ovr = 0; m_udf = 0; pend = 0;
    endtask

    task automatic step();
        bit udf_evt, ovr_evt;
        @(negedge clk);
        udf_evt = 0;
        if (r2 && cyc >= m_busy_until) begin
            if (ref_q.size() == 0) udf_evt = 1;
            else begin
                m_busy_until = cyc + 3;
                m_rd_at      = cyc + 1;
                m_dv_at      = cyc + 3;
                m_dv_byte    = ref_q.pop_front();
            end
        end
        r2 = r1;
        r1 = rd_req & ~prev_rd;
        prev_rd = rd_req;
        ovr_evt = fifo_wr & fifo_full;
        if (clr_status) begin
            m_ovr = ovr_evt; m_udf = udf_evt; m_cnt = int'(ovr_evt);
        end else begin
            m_ovr |= ovr_evt; m_udf |= udf_evt;
            m_cnt = (m_cnt + int'(ovr_evt) > 255) ? 255 : m_cnt + int'(ovr_evt);
        end
        cyc++;
        if (cyc == m_dv_at) m_data = m_dv_byte;
        if (pend) begin fifo_data = pend_byte; pend = 0; end
        check("fifo_rd_en", fifo_rd_en, cyc == m_rd_at);
        check("data_valid", data_valid, cyc == m_dv_at);
        check("data_reg", data_reg, m_data);
        check("overrun_cnt", overrun_cnt, m_cnt);
        check("status_reg", status_reg, {3'b0, cyc < m_busy_until, m_udf, m_ovr, fifo_full, fifo_empty});
        if (fifo_rd_en && fifo_q.size() > 0) begin
            pend_byte  = fifo_q.pop_front();
            pend       = 1;
            fifo_empty = (fifo_q.size() == 0);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        rd_req = 1'b0;
        #1;
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_dv", data_valid, 1'b0);
        check("rst_data", data_reg, 8'h00);
        check("rst_cnt", overrun_cnt, 8'h00);
        check("rst_status", status_reg, {6'b0, fifo_full, fifo_empty});
        repeat (3) begin @(negedge clk); cyc++; end
        rst = 1'b0;
        model_clear();
        m_busy_until = cyc;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1; rd_req = 0; clr_status = 0; fifo_empty = 1; fifo_full = 0;
        fifo_wr = 0; fifo_data = 8'h00; cyc = 0;
        model_clear();
        do_reset();
        // single read, request held high for 10 cycles
        push(8'hA5);
        rd_req = 1; run(10); rd_req = 0; run(4);
        // back-to-back reads then one against an empty FIFO
        push(8'h11); push(8'h22); push(8'h33);
        repeat (4) begin rd_req = 1; run(1); rd_req = 0; run(4); end
        run(3);
        clr_status = 1; run(1); clr_status = 0;
        // second edge lands while the first read is still in flight
        push(8'h44); push(8'h55);
        rd_req = 1; run(1); rd_req = 0; run(1); rd_req = 1; run(1); rd_req = 0; run(8);
        // overrun saturation, clear, and clear colliding with an event
        fifo_full = 1; fifo_wr = 1; run(300);
        check("ovr_sat", overrun_cnt, 8'hFF);
        fifo_wr = 0; clr_status = 1; run(1); clr_status = 0; run(1);
        fifo_wr = 1; clr_status = 1; run(1); fifo_wr = 0; clr_status = 0; run(1);
        check("ovr_clr_evt", overrun_cnt, 8'h01);
        fifo_full = 0;
        // randomized traffic
        repeat (600) begin
            if ($urandom_range(3) == 0) rd_req = ~rd_req;
            if ($urandom_range(5) == 0 && fifo_q.size() < 4) push(8'($urandom));
            fifo_wr    = ($urandom_range(2) == 0);
            fifo_full  = $urandom_range(1);
            clr_status = ($urandom_range(19) == 0);
            run(1);
        end
        rd_req = 0; fifo_wr = 0; clr_status = 0; run(6);
        // reset while in WAIT: popped byte is lost, data_reg stays clear
        push(8'h5A);
        rd_req = 1; run(4);
        do_reset();
        check("rst_mid_wait_data", data_reg, 8'h00);
        run(6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
